// File: rtl/tick_generator_if.sv
// ---------------------------------------------------------------------------
// tick_generator_if
//
// Groups the tick generator's control inputs and strobe outputs into one
// bundle. The clock and reset stay as plain ports on the modules.
//
//   master : the tick generator itself (samples controls, drives strobes)
//   slave  : the consumer side (drives controls, receives strobes)
//
// Signals
//   uart_rx            asynchronous RX line, idle high
//   baud_resync_enable RX edges realign the baud counter while high
//   led_enable         gates led_tick only
//   chain_restart      synchronous clear of the segment/bit/LED chain
//   baud_tick          one-cycle UART sample strobe
//   segment_tick       one-cycle strobe per bit segment
//   bit_tick           one-cycle strobe per encoded bit
//   bit_index          index of the current bit within the LED word
//   led_tick           one-cycle strobe per LED word
//   frame_tick         one-cycle strobe per frame
//
// IDX_W must equal $clog2(BITS_PER_LED) of the attached tick_generator.
// ---------------------------------------------------------------------------
interface tick_generator_if #(
  parameter int IDX_W = 4
);
  logic             uart_rx;
  logic             baud_resync_enable;
  logic             led_enable;
  logic             chain_restart;
  logic             baud_tick;
  logic             segment_tick;
  logic             bit_tick;
  logic [IDX_W-1:0] bit_index;
  logic             led_tick;
  logic             frame_tick;

  modport master (
    input  uart_rx,
    input  baud_resync_enable,
    input  led_enable,
    input  chain_restart,
    output baud_tick,
    output segment_tick,
    output bit_tick,
    output bit_index,
    output led_tick,
    output frame_tick
  );

  modport slave (
    output uart_rx,
    output baud_resync_enable,
    output led_enable,
    output chain_restart,
    input  baud_tick,
    input  segment_tick,
    input  bit_tick,
    input  bit_index,
    input  led_tick,
    input  frame_tick
  );
endinterface

// File: rtl/tick_generator.sv
// ---------------------------------------------------------------------------
// tick_generator
//
// Single-clock generator of one-cycle clock-enable strobes:
//   - a UART baud tick that can realign to edges on the RX line,
//   - a cascaded segment -> bit -> LED-word tick chain with a bit index,
//   - a free-running frame tick.
// Every strobe is a registered single-cycle pulse; everything lives in the
// 'clock' domain, so consumers need no clock-domain crossings.
//
// Ports
//   clock  : sole clock (nominally 12 MHz)
//   reset  : synchronous, active-high; restarts every path as from power-up
//   bus    : tick_generator_if.master (controls in, strobes out)
//
// Divider rule used by every counter c with divisor D:
//   c == D-1 : c <= 0,   tick <= 1
//   else     : c <= c+1, tick <= 0
// ---------------------------------------------------------------------------
module tick_generator #(
  parameter int BAUD_DIVISOR     = 104,     // >= 4
  parameter int SEGMENT_DIVISOR  = 4,       // >= 2
  parameter int SEGMENTS_PER_BIT = 4,       // >= 2
  parameter int BITS_PER_LED     = 16,      // >= 2
  parameter int FRAME_DIVISOR    = 200000   // >= 2
) (
  input logic                clock,
  input logic                reset,
  tick_generator_if.master   bus
);

  localparam int BAUD_W  = $clog2(BAUD_DIVISOR);
  localparam int SEG_W   = $clog2(SEGMENT_DIVISOR);
  localparam int SPB_W   = $clog2(SEGMENTS_PER_BIT);
  localparam int IDX_W   = $clog2(BITS_PER_LED);
  localparam int FRAME_W = $clog2(FRAME_DIVISOR);

  localparam logic [BAUD_W-1:0]  BAUD_LAST   = BAUD_W'(BAUD_DIVISOR - 1);
  // Loading the counter half a bit "late" puts the next tick half a bit
  // period after the detected edge, i.e. in the middle of the RX bit.
  localparam logic [BAUD_W-1:0]  BAUD_RELOAD = BAUD_W'(BAUD_DIVISOR - BAUD_DIVISOR / 2);
  localparam logic [SEG_W-1:0]   SEG_LAST    = SEG_W'(SEGMENT_DIVISOR - 1);
  localparam logic [SPB_W-1:0]   SPB_LAST    = SPB_W'(SEGMENTS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(BITS_PER_LED - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(FRAME_DIVISOR - 1);

  // -------------------------------------------------------------------------
  // Baud path: RX synchroniser, edge detect, realignable divider
  // -------------------------------------------------------------------------
  logic              rx_meta;
  logic              rx_sync;
  logic              rx_last;
  logic              rx_edge;
  logic [BAUD_W-1:0] baud_cnt;
  logic              baud_tick;

  assign rx_edge = rx_sync ^ rx_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      // Idle-high line: start "already idle" so release causes no false edge.
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_last   <= 1'b1;
      baud_cnt  <= '0;
      baud_tick <= 1'b0;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
      if (rx_edge && bus.baud_resync_enable) begin
        // Realignment wins over a coincident terminal count.
        baud_cnt  <= BAUD_RELOAD;
        baud_tick <= 1'b0;
      end else if (baud_cnt == BAUD_LAST) begin
        baud_cnt  <= '0;
        baud_tick <= 1'b1;
      end else begin
        baud_cnt  <= baud_cnt + 1'b1;
        baud_tick <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Segment / bit / LED-word chain
  // -------------------------------------------------------------------------
  logic [SEG_W-1:0] seg_cnt;
  logic [SPB_W-1:0] spb_cnt;
  logic [IDX_W-1:0] bit_index;
  logic             segment_tick;
  logic             bit_tick;
  logic             led_tick;
  logic             seg_term;
  logic             bit_term;
  logic             word_term;

  // Terminal conditions of the cascade are evaluated combinationally so that
  // all three strobes of one boundary land on the same edge.
  assign seg_term  = (seg_cnt == SEG_LAST);
  assign bit_term  = seg_term && (spb_cnt == SPB_LAST);
  assign word_term = bit_term && (bit_index == IDX_LAST);

  always_ff @(posedge clock) begin
    if (reset || bus.chain_restart) begin
      seg_cnt      <= '0;
      spb_cnt      <= '0;
      bit_index    <= '0;
      segment_tick <= 1'b0;
      bit_tick     <= 1'b0;
      led_tick     <= 1'b0;
    end else begin
      seg_cnt      <= seg_term ? '0 : seg_cnt + 1'b1;
      segment_tick <= seg_term;
      if (seg_term) begin
        spb_cnt <= (spb_cnt == SPB_LAST) ? '0 : spb_cnt + 1'b1;
      end
      // bit_index moves together with bit_tick, so during a bit_tick cycle it
      // already names the bit that is starting.
      if (bit_term) begin
        bit_index <= (bit_index == IDX_LAST) ? '0 : bit_index + 1'b1;
      end
      bit_tick <= bit_term;
      // led_enable masks the strobe only; the index keeps counting.
      led_tick <= word_term && bus.led_enable;
    end
  end

  // -------------------------------------------------------------------------
  // Frame path: free-running divider, cleared only by reset
  // -------------------------------------------------------------------------
  logic [FRAME_W-1:0] frame_cnt;
  logic               frame_tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b1;
    end else begin
      frame_cnt  <= frame_cnt + 1'b1;
      frame_tick <= 1'b0;
    end
  end

  assign bus.baud_tick    = baud_tick;
  assign bus.segment_tick = segment_tick;
  assign bus.bit_tick     = bit_tick;
  assign bus.bit_index    = bit_index;
  assign bus.led_tick     = led_tick;
  assign bus.frame_tick   = frame_tick;

endmodule

// File: tb/tb_tick_generator.sv
// ---------------------------------------------------------------------------
// tb_tick_generator
//
// Drives directed and random control patterns into tick_generator (with
// FRAME_DIVISOR overridden to 10) and compares every cycle's outputs with a
// reference model derived from edge-count arithmetic: ticks fall on multiples
// of their period counted from the last reset / restart / resync event.
// ---------------------------------------------------------------------------
module tb_tick_generator;

  localparam int BAUD  = 104;
  localparam int SD    = 4;
  localparam int SPB   = 4;
  localparam int BPL   = 16;
  localparam int FD    = 10;
  localparam int IDX_W = $clog2(BPL);

  logic clock = 1'b0;
  logic reset = 1'b1;

  tick_generator_if #(.IDX_W(IDX_W)) bus ();

  tick_generator #(
    .BAUD_DIVISOR    (BAUD),
    .SEGMENT_DIVISOR (SD),
    .SEGMENTS_PER_BIT(SPB),
    .BITS_PER_LED    (BPL),
    .FRAME_DIVISOR   (FD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic             baud;
    logic             seg;
    logic             bitt;
    logic [IDX_W-1:0] idx;
    logic             led;
    logic             frame;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   abs_edge = 0;

  // Reference model state
  int   m_e;          // edges since reset release (first low edge = 1)
  int   m_next_baud;  // edge at which the next baud tick is due
  int   m_ra;         // edge of last chain anchor (reset or restart)
  bit   rx_hist[$];   // uart_rx samples at edges n-3 .. n

  // Random-phase driver state
  bit   r_rx;
  bit   r_len;
  bit   r_rst;
  bit   r_ren;
  bit   r_cr;

  out_t mon_e;
  out_t mon_a;

  task automatic model_edge(input bit r, input bit rx, input bit ren,
                            input bit len, input bit cr);
    out_t o;
    int   k;
    bit   det;
    o = '0;
    if (r) begin
      m_e = 0;
      m_next_baud = BAUD;
      m_ra = 0;
      rx_hist.delete();
      repeat (3) rx_hist.push_back(1'b1);
    end else begin
      m_e++;
      rx_hist.push_back(rx);
      if (rx_hist.size() > 4) void'(rx_hist.pop_front());
      // An input change first sampled at edge n-2 is acted on at edge n.
      det = (rx_hist[1] != rx_hist[0]);
      if (det && ren) begin
        m_next_baud = m_e + BAUD / 2;
      end else if (m_e == m_next_baud) begin
        o.baud = 1'b1;
        m_next_baud = m_next_baud + BAUD;
      end
      o.frame = ((m_e % FD) == 0);
      if (cr) begin
        m_ra = m_e;
      end else begin
        k      = m_e - m_ra;
        o.seg  = ((k % SD) == 0);
        o.bitt = ((k % (SD * SPB)) == 0);
        o.idx  = IDX_W'((k / (SD * SPB)) % BPL);
        o.led  = len && ((k % (SD * SPB * BPL)) == 0);
      end
    end
    exp_q.push_back(o);
  endtask

  task automatic cycle(input bit r, input bit rx, input bit ren,
                       input bit len, input bit cr);
    @(negedge clock);
    reset                  = r;
    bus.uart_rx            = rx;
    bus.baud_resync_enable = ren;
    bus.led_enable         = len;
    bus.chain_restart      = cr;
    @(posedge clock);
    abs_edge++;
    model_edge(r, rx, ren, len, cr);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, abs_edge, got, want);
    end
  endtask

  // Scoreboard monitor: one expected output vector per clock edge.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e       = exp_q.pop_front();
      mon_a.baud  = bus.baud_tick;
      mon_a.seg   = bus.segment_tick;
      mon_a.bitt  = bus.bit_tick;
      mon_a.idx   = bus.bit_index;
      mon_a.led   = bus.led_tick;
      mon_a.frame = bus.frame_tick;
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs edge=%0d got baud=%0b seg=%0b bit=%0b idx=%0d led=%0b frame=%0b expected baud=%0b seg=%0b bit=%0b idx=%0d led=%0b frame=%0b",
                 abs_edge, mon_a.baud, mon_a.seg, mon_a.bitt, mon_a.idx, mon_a.led, mon_a.frame,
                 mon_e.baud, mon_e.seg, mon_e.bitt, mon_e.idx, mon_e.led, mon_e.frame);
      end
    end
  end

  initial begin
    bus.uart_rx            = 1'b1;
    bus.baud_resync_enable = 1'b1;
    bus.led_enable         = 1'b1;
    bus.chain_restart      = 1'b0;
    m_e = 0;
    m_next_baud = BAUD;
    m_ra = 0;
    repeat (3) rx_hist.push_back(1'b1);

    // Power-up reset
    repeat (3) cycle(1, 1, 1, 1, 0);
    #1;
    chk("reset_outputs_zero", int'({bus.baud_tick, bus.segment_tick, bus.bit_tick,
                                    bus.bit_index, bus.led_tick, bus.frame_tick}), 0);

    // Defaults, resync enabled, RX falls for edge 1000
    for (int n = 1; n <= 1200; n++) begin
      cycle(0, (n >= 1000) ? 1'b0 : 1'b1, 1, 1, 0);
      #1;
      if (n == 104 || n == 208 || n == 312 || n == 1054 || n == 1158)
        chk("baud_tick_due", bus.baud_tick, 1);
      if (n == 1040) chk("baud_old_phase_gone", bus.baud_tick, 0);
      if (n == 256 || n == 512) chk("led_tick_due", bus.led_tick, 1);
      if (n == 10 || n == 20 || n == 30) chk("frame_tick_due", bus.frame_tick, 1);
      if (n == 16) chk("first_bit_tick", bus.bit_tick, 1);
    end

    // Same RX stimulus with resync disabled: original phase kept
    repeat (2) cycle(1, 1, 0, 1, 0);
    for (int n = 1; n <= 1200; n++) begin
      cycle(0, (n >= 1000) ? 1'b0 : 1'b1, 0, 1, 0);
      #1;
      if (n == 1040 || n == 1144) chk("baud_no_resync_due", bus.baud_tick, 1);
      if (n == 1054) chk("baud_no_resync_quiet", bus.baud_tick, 0);
    end

    // led_enable low across a wrap, raised mid-word
    repeat (2) cycle(1, 1, 1, 1, 0);
    for (int n = 1; n <= 600; n++) begin
      cycle(0, 1, 1, !(n >= 200 && n < 300), 0);
      #1;
      if (n == 256) begin
        chk("led_masked", bus.led_tick, 0);
        chk("bit_tick_unmasked", bus.bit_tick, 1);
        chk("bit_index_wrapped", bus.bit_index, 0);
      end
      if (n == 512) chk("led_after_enable", bus.led_tick, 1);
    end

    // chain_restart on the edge a bit_tick is due
    repeat (2) cycle(1, 1, 1, 1, 0);
    for (int n = 1; n <= 300; n++) begin
      cycle(0, 1, 1, 1, n == 32);
      #1;
      if (n == 32) begin
        chk("restart_bit_tick", bus.bit_tick, 0);
        chk("restart_bit_index", bus.bit_index, 0);
      end
      if (n == 36) chk("restart_next_segment", bus.segment_tick, 1);
      if (n == 48) chk("restart_next_bit_index", bus.bit_index, 1);
      if (n == 104) chk("restart_baud_phase", bus.baud_tick, 1);
      if (n == 40) chk("restart_frame_phase", bus.frame_tick, 1);
    end

    // Reset pulsed at edge 25
    repeat (2) cycle(1, 1, 1, 1, 0);
    for (int n = 1; n <= 40; n++) begin
      cycle(n == 25, 1, 1, 1, 0);
      #1;
      if (n == 26)
        chk("reset_mid_outputs_zero", int'({bus.baud_tick, bus.segment_tick, bus.bit_tick,
                                            bus.bit_index, bus.led_tick, bus.frame_tick}), 0);
      if (n == 30) chk("frame_old_phase_gone", bus.frame_tick, 0);
      if (n == 35) chk("frame_after_reset", bus.frame_tick, 1);
    end

    // Random traffic
    r_rx  = 1'b1;
    r_len = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) r_rx = ~r_rx;
      if ($urandom_range(0, 199) == 0) r_len = ~r_len;
      r_rst = ($urandom_range(0, 999) == 0);
      r_ren = ($urandom_range(0, 3) != 0);
      r_cr  = ($urandom_range(0, 299) == 0);
      cycle(r_rst, r_rx, r_ren, r_len, r_cr);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_generator.md
# tick_generator

Single-clock, parametrised replacement for the multi-clock divider block. It produces one-cycle clock-enable strobes instead of derived clocks: a UART sample tick that realigns to RX edges, a cascaded segment/bit/LED tick chain for the LED bit encoder, and a frame-rate tick. All logic runs in one clock domain, so downstream encoder, UART and frame logic need no clock-domain crossings.

## Interface
- BAUD_DIVISOR, 104: clocks per UART bit; 12 MHz / 104 ≈ 115385 Bd (0.16 % error); legal range ≥ 4.
- SEGMENT_DIVISOR, 4: clocks per bit segment (3 MHz); ≥ 2.
- SEGMENTS_PER_BIT, 4: segment ticks per encoded bit (750 kHz); ≥ 2.
- BITS_PER_LED, 16: bit ticks per LED word; ≥ 2.
- FRAME_DIVISOR, 200000: clocks per frame tick (60 Hz); ≥ 2.
- Counter widths are $clog2 of the respective divisor.
- clock  in  1  sole clock, nominally 12 MHz.
- reset  in  1  synchronous, active-high.
- uart_rx  in  1  asynchronous RX line; idle high.
- baud_resync_enable  in  1  when high, RX edges realign the baud counter.
- led_enable  in  1  gates led_tick only; counters run regardless.
- chain_restart  in  1  synchronous clear of the segment/bit/LED chain.
- baud_tick  out  1  one-cycle UART sample strobe.
- segment_tick  out  1  one-cycle strobe per bit segment.
- bit_tick  out  1  one-cycle strobe per encoded bit.
- bit_index  out  $clog2(BITS_PER_LED)  index of the current bit within the LED word.
- led_tick  out  1  one-cycle strobe per LED word.
- frame_tick  out  1  one-cycle strobe per frame.

## Operation
- Reset values: all tick outputs 0, bit_index 0, all counters 0, RX synchroniser flops (rx_meta, rx_sync, rx_last) 1.
- Generic divider rule, for a counter c with divisor D:
  - if c == D−1: c ← 0 and tick ← 1;
  - otherwise: c ← c+1 and tick ← 0.
  - Every tick is a registered single-cycle pulse.
- Baud path:
  - uart_rx passes through rx_meta → rx_sync; rx_last holds the previous rx_sync.
  - An edge is detected when rx_sync ≠ rx_last.
  - On an edge with baud_resync_enable high: baud counter ← BAUD_DIVISOR − BAUD_DIVISOR/2 and baud_tick ← 0. This takes priority over terminal count.
  - On an edge with baud_resync_enable low, the edge is ignored.
- Chain:
  - The segment counter divides clock by SEGMENT_DIVISOR.
  - The per-bit counter advances only on segment_tick cycles. bit_tick fires in the same cycle as the SEGMENTS_PER_BIT-th segment_tick.
  - bit_index advances on each bit_tick and wraps from BITS_PER_LED−1 to 0.
  - led_tick = (bit_tick and bit_index wraps to 0) and led_enable, all in the same cycle.
  - Disabling led_enable never stalls bit_index.
- chain_restart:
  - Clears the segment counter, per-bit counter and bit_index.
  - Forces segment_tick, bit_tick and led_tick to 0 that cycle.
  - Does not touch the baud or frame paths.
- Frame path: independent free-running divider by FRAME_DIVISOR, affected only by reset.
- Priority: reset > chain_restart / RX resync > terminal count.

## Timing
- Edges are numbered from the first rising edge with reset low (edge 1).
- Free-run (first tick at edge D, then every D edges):
  - baud_tick first at edge BAUD_DIVISOR, then every BAUD_DIVISOR.
  - segment_tick at edges SEGMENT_DIVISOR·k.
  - bit_tick at edges SEGMENT_DIVISOR·SEGMENTS_PER_BIT·k.
  - led_tick every SEGMENT_DIVISOR·SEGMENTS_PER_BIT·BITS_PER_LED edges.
- RX latency: a uart_rx change meeting setup before edge k is detected (and the counter loaded) at edge k+2. The next baud_tick occurs at edge k+2+BAUD_DIVISOR/2, then every BAUD_DIVISOR.
- Repeated edges before the tick reload again; the tick follows the last edge.
- chain_restart high at edge r (last high cycle): first segment_tick at edge r+SEGMENT_DIVISOR.
- bit_index is valid in the cycle of bit_tick and holds until the next bit_tick.
- Reset mid-operation: outputs read 0 in the cycle after the reset edge. The sequence restarts exactly as from power-up.

## Test plan
- Defaults, reset released: segment_tick at edges 4, 8, 12…; bit_tick at 16, 32…; bit_index reads 0,1,…,15,0; led_tick at edge 256 and 512; no double pulses.
- Baud free-run: baud_tick at edges 104, 208, 312; exactly 1 cycle wide.
- RX resync: falling uart_rx before edge 1000 with resync enabled → baud_tick at edge 1054, then 1158. Same stimulus with resync disabled → tick keeps its original 104-cycle phase.
- led_enable low across a wrap → bit_tick and bit_index unchanged, no led_tick. Raise led_enable mid-word → led_tick only at the next wrap of bit_index.
- chain_restart asserted on the cycle a bit_tick is due → no tick that cycle, bit_index 0, next segment_tick exactly 4 edges after the restart edge. baud_tick and frame_tick phase unchanged.
- FRAME_DIVISOR=10 override: frame_tick at edges 10, 20, 30. Reset pulsed at edge 25 → next frame_tick at edge 35, all outputs 0 at edge 26.
